// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared constants for the 8-point FFT datapath
package fft8_pkg;

  localparam int DW    = 9;
  localparam int NPT   = 8;
  localparam int PTR_W = 3;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NPT - 1);

endpackage

// File: rtl/fft8_frame_bank.sv
// rtl/fft8_frame_bank.sv - one frame of complex samples, indexed write, parallel read
module fft8_frame_bank
  import fft8_pkg::*;
#(
  parameter int DW  = fft8_pkg::DW,
  parameter int NPT = fft8_pkg::NPT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [PTR_W-1:0]         idx,
  input  logic [DW-1:0]            wr_re,
  input  logic [DW-1:0]            wr_im,
  output logic [NPT-1:0][DW-1:0]   re,
  output logic [NPT-1:0][DW-1:0]   im
);

  // storage words: cleared on reset, one word written per enabled cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      re <= '0;
      im <= '0;
    end else if (we) begin
      re[idx] <= wr_re;
      im[idx] <= wr_im;
    end
  end

endmodule

// File: rtl/fft8_sample_loader.sv
// rtl/fft8_sample_loader.sv - serial-to-parallel ping-pong frame loader for the FFT core
module fft8_sample_loader
  import fft8_pkg::*;
#(
  parameter int DW  = fft8_pkg::DW,
  parameter int NPT = fft8_pkg::NPT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          in_last,
  output logic [DW-1:0] smpr0,
  output logic [DW-1:0] smpr1,
  output logic [DW-1:0] smpr2,
  output logic [DW-1:0] smpr3,
  output logic [DW-1:0] smpr4,
  output logic [DW-1:0] smpr5,
  output logic [DW-1:0] smpr6,
  output logic [DW-1:0] smpr7,
  output logic [DW-1:0] smpi0,
  output logic [DW-1:0] smpi1,
  output logic [DW-1:0] smpi2,
  output logic [DW-1:0] smpi3,
  output logic [DW-1:0] smpi4,
  output logic [DW-1:0] smpi5,
  output logic [DW-1:0] smpi6,
  output logic [DW-1:0] smpi7,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err_sync
);

  logic             wr_bank;
  logic             rd_bank;
  logic [PTR_W-1:0] wr_ptr;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic accept;
  logic at_last;
  logic commit;
  logic sync_bad;
  logic rel_frame;

  logic [NPT-1:0][DW-1:0] re_a, im_a, re_b, im_b;
  logic [NPT-1:0][DW-1:0] re_sel, im_sel;

  // handshake decode and next bank occupancy; a commit and a release always hit
  // different banks because the write side only ever targets an empty bank
  always_comb begin
    in_ready  = !full[wr_bank];
    accept    = in_valid && in_ready;
    at_last   = (wr_ptr == LAST_IDX);
    commit    = accept && at_last && in_last;
    sync_bad  = accept && (at_last != in_last);
    out_valid = full[rd_bank];
    rel_frame = out_valid && out_ready;
    full_nxt  = full;
    if (rel_frame) full_nxt[rd_bank] = 1'b0;
    if (commit)    full_nxt[wr_bank] = 1'b1;
    re_sel    = rd_bank ? re_b : re_a;
    im_sel    = rd_bank ? im_b : im_a;
  end

  // bank pointers, write index, occupancy flags and the alignment-error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_ptr   <= '0;
      full     <= '0;
      err_sync <= 1'b0;
    end else begin
      full     <= full_nxt;
      err_sync <= sync_bad;
      if (commit)    wr_bank <= ~wr_bank;
      if (rel_frame) rd_bank <= ~rd_bank;
      if (accept)    wr_ptr  <= (at_last || in_last) ? '0 : wr_ptr + PTR_W'(1);
    end
  end

  fft8_frame_bank #(.DW(DW), .NPT(NPT)) u_bank_a (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !wr_bank),
    .idx   (wr_ptr),
    .wr_re (in_re),
    .wr_im (in_im),
    .re    (re_a),
    .im    (im_a)
  );

  fft8_frame_bank #(.DW(DW), .NPT(NPT)) u_bank_b (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && wr_bank),
    .idx   (wr_ptr),
    .wr_re (in_re),
    .wr_im (in_im),
    .re    (re_b),
    .im    (im_b)
  );

  assign smpr0 = re_sel[0];
  assign smpr1 = re_sel[1];
  assign smpr2 = re_sel[2];
  assign smpr3 = re_sel[3];
  assign smpr4 = re_sel[4];
  assign smpr5 = re_sel[5];
  assign smpr6 = re_sel[6];
  assign smpr7 = re_sel[7];
  assign smpi0 = im_sel[0];
  assign smpi1 = im_sel[1];
  assign smpi2 = im_sel[2];
  assign smpi3 = im_sel[3];
  assign smpi4 = im_sel[4];
  assign smpi5 = im_sel[5];
  assign smpi6 = im_sel[6];
  assign smpi7 = im_sel[7];

endmodule

// File: doc/fft8_sample_loader.md
FFT8_SAMPLE_LOADER -- requirements
Module: fft8_sample_loader

Interface
REQ-001 SHALL have parameter DW, default 9, meaning sample component width (two's complement).
REQ-002 SHALL have parameter NPT, default 8, meaning samples per frame; only 8 is supported.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  serial sample valid.
REQ-006 SHALL have port in_ready  output  1  loader can accept a sample.
REQ-007 SHALL have port in_re  input  DW  sample real part.
REQ-008 SHALL have port in_im  input  DW  sample imaginary part.
REQ-009 SHALL have port in_last  input  1  marks sample index 7 of a frame.
REQ-010 SHALL have ports smpr0..smpr7  output  DW each  frame real parts, natural order (index 0 = first accepted).
REQ-011 SHALL have ports smpi0..smpi7  output  DW each  frame imaginary parts, natural order.
REQ-012 SHALL have port out_valid  output  1  complete frame presented on smpr*/smpi*.
REQ-013 SHALL have port out_ready  input  1  downstream FFT consumes the frame.
REQ-014 SHALL have port err_sync  output  1  one-cycle pulse on a frame-alignment error.

Function
REQ-015 SHALL hold two frame banks (A, B) in ping-pong, with state wr_bank, wr_ptr (0..7), rd_bank, full[A], full[B].
REQ-016 SHALL drive in_ready = !full[wr_bank] combinationally from registered state.
REQ-017 SHALL accept a sample when in_valid && in_ready: write in_re/in_im to bank[wr_bank][wr_ptr].
REQ-018 SHALL handle wr_ptr<7 with in_last=0 by incrementing wr_ptr.
REQ-019 SHALL handle wr_ptr==7 with in_last=1 by setting full[wr_bank], toggling wr_bank and clearing wr_ptr.
REQ-020 SHALL treat in_last=1 at wr_ptr<7 as a sync error: pulse err_sync next cycle, discard the partial frame, set wr_ptr=0, leave full unchanged.
REQ-021 SHALL treat in_last=0 at wr_ptr==7 as a sync error: pulse err_sync next cycle, discard the partial frame, set wr_ptr=0, leave full unchanged.
REQ-022 SHALL drive out_valid = full[rd_bank] and smpr*/smpi* = bank[rd_bank] contents.
REQ-023 SHALL, on out_valid && out_ready, clear full[rd_bank] and toggle rd_bank.
REQ-024 SHALL hold smpr*/smpi*/out_valid stable while out_valid && !out_ready.
REQ-025 SHALL raise out_valid the cycle after the last-sample acceptance edge (latency 1).
REQ-026 SHALL apply a commit on one bank and a release on the other in the same cycle, both taking effect.
REQ-027 SHALL never let the write bank equal a full bank; the wr_bank/rd_bank collision is impossible by construction.
REQ-028 SHALL sustain 1 sample/cycle with no in_ready drop when out_ready is asserted within 8 cycles of out_valid.
REQ-029 SHALL deassert in_ready with both banks full, resuming in the cycle after a release.
REQ-030 SHALL pass data bit-exact: no scaling, rounding or sign handling.

Reset
REQ-031 SHALL, at a clk edge with rst=0, clear wr_bank, rd_bank, wr_ptr, full[A], full[B], err_sync and all bank storage.
REQ-032 SHALL, after reset, present out_valid=0, in_ready=1, err_sync=0 and all smpr*/smpi*=0.
REQ-033 SHALL drop any in-flight partial or complete frame on reset mid-operation; the first post-reset sample is index 0.

Structure
REQ-034 SHALL place DW, NPT and PTR_W=3 in shared package fft8_pkg, which the FFT core also uses.
REQ-035 SHALL instantiate sub-module fft8_frame_bank twice: 8x(2xDW) registers with write enable, 3-bit index, and all 16 words exposed in parallel.

Verification
REQ-036 SHALL cover: reset, then in_re=k, in_im=-k for k=0..7, in_last on k=7 -> out_valid one cycle later; smpr3=3, smpi3=9'h1FD.
REQ-037 SHALL cover: 3 back-to-back frames with out_ready=1 -> in_ready never drops and frames appear in order.
REQ-038 SHALL cover: out_ready=0 for 2 frames -> in_ready=0 after 16th acceptance; one out_ready pulse -> in_ready=1 next cycle and frame 2 follows.
REQ-039 SHALL cover: in_last at sample 4 -> err_sync one-cycle pulse, no out_valid; next 8 samples form a correct frame.
REQ-040 SHALL cover: in_last=0 at sample 7 -> err_sync pulse, frame discarded.
REQ-041 SHALL cover: rst=0 asserted after 5 samples while bank B is full -> all outputs 0, in_ready=1, out_valid=0.
